// File: rtl/tex_sram_arbiter_if.sv
// Signal bundle between the texture SRAM arbiter and its neighbours: VGA counters,
// rasterizer texel port, host byte loader and the single-port SRAM macro.
interface tex_sram_arbiter_if;
  logic [9:0] x;
  logic [9:0] y;
  logic [6:0] u_addr;
  logic [6:0] v_addr;
  logic       tex_sel;
  logic       load_start;
  logic       load_plane;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       load_busy;
  logic       load_done;
  logic       sram_cen;
  logic       sram_wen;
  logic [11:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;
  logic       texel0;
  logic       texel1;

  modport slave (
    input  x, y, u_addr, v_addr, tex_sel,
    input  load_start, load_plane, load_data, load_valid, sram_dout,
    output load_ready, load_busy, load_done,
    output sram_cen, sram_wen, sram_addr, sram_din, texel0, texel1
  );

  modport master (
    output x, y, u_addr, v_addr, tex_sel,
    output load_start, load_plane, load_data, load_valid, sram_dout,
    input  load_ready, load_busy, load_done,
    input  sram_cen, sram_wen, sram_addr, sram_din, texel0, texel1
  );
endinterface

// File: rtl/tex_sram_arbiter.sv
// Arbitrates the texture SRAM: raster texel reads own it during active video,
// buffered loader bytes are written only during blanking.
module tex_sram_arbiter #(
  parameter int FIFO_DEPTH  = 4,
  parameter int PLANE_BYTES = 2048
) (
  input  logic                clk,
  input  logic                reset_n,
  tex_sram_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state_o
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic        plane_q;
  logic [11:0] acc_cnt_q;
  logic [11:0] wr_cnt_q;

  logic [7:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;

  logic        rd_vld_q;
  logic        sel_q;
  logic [2:0]  bit_idx_q;
  logic        texel0_q, texel1_q;

  logic active, fifo_full, fifo_empty, load_ready, push, rd_slot, wr_slot;

  assign active     = (bus.x < 10'd640) && (bus.y < 10'd480);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // Loader handshake: a byte transfers on any cycle where load_valid && load_ready;
  // load_valid may not depend on load_ready, and load_data must be stable while valid.
  assign load_ready = (state_q == ST_LOAD) && !fifo_full && (acc_cnt_q < 12'(PLANE_BYTES));
  assign push       = bus.load_valid && load_ready;
  assign rd_slot    = active;
  assign wr_slot    = !active && (state_q == ST_LOAD) && !fifo_empty;

  assign wr_ptr_d = push    ? wr_ptr_q + {{PW{1'b0}}, 1'b1} : wr_ptr_q;
  assign rd_ptr_d = wr_slot ? rd_ptr_q + {{PW{1'b0}}, 1'b1} : rd_ptr_q;

  always_comb begin
    bus.sram_cen  = 1'b1;
    bus.sram_wen  = 1'b1;
    bus.sram_addr = 12'd0;
    bus.sram_din  = 8'd0;
    if (rd_slot) begin
      bus.sram_cen  = 1'b0;
      bus.sram_addr = {bus.tex_sel, bus.v_addr, bus.u_addr[6:3]};
    end else if (wr_slot) begin
      bus.sram_cen  = 1'b0;
      bus.sram_wen  = 1'b0;
      bus.sram_addr = {plane_q, wr_cnt_q[10:0]};
      bus.sram_din  = fifo_mem_q[rd_ptr_q[PW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PW-1:0]] <= bus.load_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      plane_q   <= 1'b0;
      acc_cnt_q <= 12'd0;
      wr_cnt_q  <= 12'd0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.load_start) begin
          state_q   <= ST_LOAD;
          plane_q   <= bus.load_plane;
          acc_cnt_q <= 12'd0;
          wr_cnt_q  <= 12'd0;
        end
        ST_LOAD: begin
          if (push) acc_cnt_q <= acc_cnt_q + 12'd1;
          if (wr_slot) begin
            wr_cnt_q <= wr_cnt_q + 12'd1;
            if (wr_cnt_q == 12'(PLANE_BYTES - 1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Texel bits hold between reads so blanking never disturbs the last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q  <= 1'b0;
      sel_q     <= 1'b0;
      bit_idx_q <= 3'd0;
      texel0_q  <= 1'b0;
      texel1_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_slot;
      if (rd_slot) begin
        sel_q     <= bus.tex_sel;
        bit_idx_q <= bus.u_addr[2:0];
      end
      if (rd_vld_q) begin
        texel0_q <= sel_q ? 1'b0 : bus.sram_dout[bit_idx_q];
        texel1_q <= sel_q ? bus.sram_dout[bit_idx_q] : 1'b0;
      end
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.load_busy  = (state_q != ST_IDLE);
  assign bus.load_done  = (state_q == ST_DONE);
  assign bus.texel0     = texel0_q;
  assign bus.texel1     = texel1_q;
  assign dbg_state_o    = state_q;
endmodule
